// File: rtl/ula_pkg.sv
// ula_pkg
// Shared definitions for the ULA (arithmetic/logic unit) slice:
//   - DEFAULT_WIDTH : default data path width
//   - OP_*          : 3-bit operation codes presented on OpSelect
package ula_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_NAND  = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_OUT   = 3'b100;
    localparam logic [2:0] OP_PASSR = 3'b101;
    localparam logic [2:0] OP_SHL   = 3'b110;
    localparam logic [2:0] OP_SHR   = 3'b111;

endpackage

// File: rtl/ula_addsub.sv
// ula_addsub
// Combinational adder/subtractor shared by ADD and SUB.
// Vectors use ascending ranges: index 0 is the MSB (sign bit).
// Ports:
//   a        in  WIDTH  first operand
//   b        in  WIDTH  second operand
//   sub      in  1      0: a + b, 1: a + ~b + 1
//   sum      out WIDTH  result mod 2^WIDTH
//   carry    out 1      carry-out of the top bit (no-borrow when sub=1)
//   overflow out 1      signed two's-complement overflow
module ula_addsub
    import ula_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic             sub,
    output logic [0:WIDTH-1] sum,
    output logic             carry,
    output logic             overflow
);

    logic [0:WIDTH-1] b_eff;
    logic [WIDTH:0]   full;

    // Subtraction reuses the adder by inverting b and injecting the +1
    // through the carry-in, so carry-out directly means "no borrow".
    assign b_eff = sub ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign sum   = full[WIDTH-1:0];
    assign carry = full[WIDTH];

    // Overflow when the effective operands agree in sign but the sum does
    // not; for SUB this is "a and b differ in sign and sum differs from a".
    assign overflow = (a[0] == b_eff[0]) && (sum[0] != a[0]);

endmodule

// File: rtl/ula_unit.sv
// ula_unit
// Single-cycle-latency ALU: combinational decode/mux followed by one
// register stage for all outputs. Index 0 of every data vector is the MSB.
// Ports:
//   clock     in  1      rising-edge clock
//   reset     in  1      synchronous, active-low reset
//   in_valid  in  1      operands/opcode valid this cycle
//   A         in  WIDTH  accumulator operand
//   Ry        in  WIDTH  register operand
//   OpSelect  in  3      operation code (see ula_pkg)
//   result    out WIDTH  registered result
//   zero      out 1      registered "result is all zeros"
//   carry     out 1      registered carry / no-borrow (ADD/SUB only)
//   overflow  out 1      registered signed overflow (ADD/SUB only)
//   out_valid out 1      one-cycle pulse per accepted operation
module ula_unit
    import ula_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [0:WIDTH-1] A,
    input  logic [0:WIDTH-1] Ry,
    input  logic [0:2]       OpSelect,
    output logic [0:WIDTH-1] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             out_valid
);

    logic [0:WIDTH-1] as_sum;
    logic             as_carry;
    logic             as_overflow;
    logic             is_sub;

    logic [0:WIDTH-1] next_result;
    logic             next_carry;
    logic             next_overflow;
    logic             next_zero;

    assign is_sub = (OpSelect == OP_SUB);

    ula_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a       (A),
        .b       (Ry),
        .sub     (is_sub),
        .sum     (as_sum),
        .carry   (as_carry),
        .overflow(as_overflow)
    );

    // Opcode decode and result mux; flags other than zero are only
    // meaningful for ADD/SUB and default to 0 for every other operation.
    always_comb begin
        next_result   = '0;
        next_carry    = 1'b0;
        next_overflow = 1'b0;
        case (OpSelect)
            OP_ADD, OP_SUB: begin
                next_result   = as_sum;
                next_carry    = as_carry;
                next_overflow = as_overflow;
            end
            OP_NAND:  next_result = ~(A & Ry);
            OP_OR:    next_result = A | Ry;
            OP_OUT:   next_result = A;
            OP_PASSR: next_result = Ry;
            OP_SHL:   next_result = A << 1;
            OP_SHR:   next_result = A >> 1;
            default:  next_result = '0;
        endcase
    end

    // zero comes from the freshly computed value so it lines up with result.
    assign next_zero = ~|next_result;

    // Output register; reset wins over in_valid, and idle cycles hold the
    // last result and flags while dropping out_valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            result    <= '0;
            zero      <= 1'b1;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= next_result;
                zero     <= next_zero;
                carry    <= next_carry;
                overflow <= next_overflow;
            end
        end
    end

endmodule

// File: tb/tb_ula_unit.sv
// tb_ula_unit
// Directed self-checking bench for ula_unit with hand-computed expectations.
module tb_ula_unit;

    localparam logic [2:0] ADD   = 3'b000;
    localparam logic [2:0] SUB   = 3'b001;
    localparam logic [2:0] NAND_ = 3'b010;
    localparam logic [2:0] OR_   = 3'b011;
    localparam logic [2:0] OUT   = 3'b100;
    localparam logic [2:0] PASSR = 3'b101;
    localparam logic [2:0] SHL   = 3'b110;
    localparam logic [2:0] SHR   = 3'b111;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [0:15] A;
    logic [0:15] Ry;
    logic [0:2]  OpSelect;
    logic [0:15] result;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        out_valid;

    int vectors;
    int miscompares;

    ula_unit #(
        .WIDTH(16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .A        (A),
        .Ry       (Ry),
        .OpSelect (OpSelect),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow),
        .out_valid(out_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive inputs away from the rising edge, let one edge pass, then
    // settle so the outputs are sampled between edges.
    task automatic applyStimulus(input logic v, input logic [2:0] op,
                                 input logic [15:0] a, input logic [15:0] r);
        @(negedge clock);
        in_valid = v;
        OpSelect = op;
        A        = a;
        Ry       = r;
        @(posedge clock);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] exp_result,
                               input logic exp_zero, input logic exp_carry,
                               input logic exp_overflow, input logic exp_valid);
        checkValue({tag, ".result"},    32'(result),    32'(exp_result));
        checkValue({tag, ".zero"},      32'(zero),      32'(exp_zero));
        checkValue({tag, ".carry"},     32'(carry),     32'(exp_carry));
        checkValue({tag, ".overflow"},  32'(overflow),  32'(exp_overflow));
        checkValue({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        in_valid    = 1'b0;
        OpSelect    = 3'b000;
        A           = '0;
        Ry          = '0;

        // Reset held low while an ADD 2+1 is offered: it must be discarded.
        applyStimulus(1'b1, ADD, 16'd2, 16'd1);
        applyStimulus(1'b1, ADD, 16'd2, 16'd1);
        checkOutput("reset_add", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

        reset = 1'b1;
        applyStimulus(1'b1, SHL, 16'h8001, 16'h0000);
        checkOutput("shl_8001", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, ADD, 16'd2, 16'd1);
        checkOutput("add_2_1", 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, SUB, 16'd6, 16'd2);
        checkOutput("sub_6_2", 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1);

        applyStimulus(1'b1, SUB, 16'd5, 16'd5);
        checkOutput("sub_5_5", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);

        applyStimulus(1'b1, SUB, 16'd2, 16'd6);
        checkOutput("sub_2_6", 16'hFFFC, 1'b0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, SUB, 16'h8000, 16'h0001);
        checkOutput("sub_ovf", 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b1);

        applyStimulus(1'b1, NAND_, 16'h0001, 16'h0000);
        checkOutput("nand_1_0", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, NAND_, 16'hFFFF, 16'hFFFF);
        checkOutput("nand_ff", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, OR_, 16'h00F0, 16'h0F01);
        checkOutput("or", 16'h0FF1, 1'b0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, OUT, 16'h0007, 16'h1234);
        checkOutput("out", 16'h0007, 1'b0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, PASSR, 16'h0007, 16'h1234);
        checkOutput("passr", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, ADD, 16'h7FFF, 16'h0001);
        checkOutput("add_ovf", 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);

        applyStimulus(1'b1, ADD, 16'hFFFF, 16'h0001);
        checkOutput("add_carry", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);

        applyStimulus(1'b1, ADD, 16'h8000, 16'h8000);
        checkOutput("add_neg_ovf", 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);

        // Logic op right after a carry/overflow op must clear both flags.
        applyStimulus(1'b1, SHR, 16'h8001, 16'h0000);
        checkOutput("shr_8001", 16'h4000, 1'b0, 1'b0, 1'b0, 1'b1);
        checkValue("shr_bit_order", 32'(result[1]), 32'd1);

        // Idle cycle: everything holds, out_valid drops.
        applyStimulus(1'b0, ADD, 16'h1111, 16'h2222);
        checkOutput("idle_hold", 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Mid-run reset, then first operation after release.
        reset = 1'b0;
        applyStimulus(1'b0, OR_, 16'h0000, 16'h0000);
        checkOutput("reset_mid", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b1, SUB, 16'h0010, 16'h0001);
        checkOutput("post_reset_sub", 16'h000F, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ula_unit.md
ULA_UNIT -- requirements
Module: ula_unit

Interface
REQ-001 Parameter WIDTH, default 16, data path width in bits.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-low; sampled only on the rising edge of clock.
REQ-004 in_valid  input  1  high when A, Ry and OpSelect hold an operation to execute.
REQ-005 A  input  WIDTH  first operand (accumulator); index 0 is the MSB, index WIDTH-1 is the LSB.
REQ-006 Ry  input  WIDTH  second operand (register); same bit ordering as A.
REQ-007 OpSelect  input  3  operation code; index 0 is the MSB.
REQ-008 result  output  WIDTH  registered operation result; same bit ordering as A.
REQ-009 zero  output  1  registered flag, high when result is all zeros.
REQ-010 carry  output  1  registered carry-out (ADD) or no-borrow (SUB); 0 for all other ops.
REQ-011 overflow  output  1  registered signed two's-complement overflow for ADD/SUB; 0 for all other ops.
REQ-012 out_valid  output  1  high for exactly one cycle per accepted operation.

Function
REQ-013 OpSelect 000 ADD: result = (A + Ry) mod 2^WIDTH.
REQ-014 OpSelect 001 SUB: result = (A - Ry) mod 2^WIDTH, computed as A + ~Ry + 1.
REQ-015 OpSelect 010 NAND: result = bitwise ~(A & Ry).
REQ-016 OpSelect 011 OR: result = bitwise A | Ry.
REQ-017 OpSelect 100 OUT: result = A (pass-through; Ry ignored).
REQ-018 OpSelect 101 PASSR: result = Ry (A ignored).
REQ-019 OpSelect 110 SHL: result = A shifted left by one toward the MSB, LSB filled with 0.
REQ-020 OpSelect 111 SHR: result = A shifted right by one, logical, MSB filled with 0.
REQ-021 Latency is exactly one cycle: operands sampled at edge N with in_valid=1 appear on the outputs after edge N, with out_valid=1.
REQ-022 in_valid=0 at an edge: result, zero, carry and overflow hold their previous values, and out_valid=0.
REQ-023 Back-to-back operations are accepted every cycle with no stall; there is no ready signal.
REQ-024 zero is derived from the same-cycle computed result, never from the previous registered value.
REQ-025 ADD: carry = bit WIDTH of the unsigned sum; overflow = operands of equal sign giving a result of the opposite sign.
REQ-026 SUB: carry = 1 when A >= Ry (unsigned); overflow = operands of different sign where the result sign differs from A.

Reset
REQ-027 reset low at a rising edge sets result=0, zero=1, carry=0, overflow=0, out_valid=0.
REQ-028 Reset takes priority over in_valid; an operation presented in a reset cycle is discarded.
REQ-029 After reset is released, the first accepted operation completes with the normal one-cycle latency.

Structure
REQ-030 Package ula_pkg holds the 3-bit opcode constants (OP_ADD, OP_SUB, OP_NAND, OP_OR, OP_OUT, OP_PASSR, OP_SHL, OP_SHR) and the default WIDTH.
REQ-031 One sub-module, ula_addsub, is purely combinational and provides the sum, carry and overflow for both ADD and SUB through a subtract control input.
REQ-032 The opcode decode and result mux are combinational, followed by a single register stage for all outputs.

Verification
REQ-033 ADD A=2, Ry=1 -> result=3, zero=0, carry=0, overflow=0 one cycle later.
REQ-034 SUB A=6, Ry=2 -> result=4, carry=1; SUB A=5, Ry=5 -> result=0, zero=1, carry=1.
REQ-035 NAND A=1, Ry=0 -> result=0xFFFF, zero=0; NAND A=0xFFFF, Ry=0xFFFF -> result=0, zero=1.
REQ-036 OUT A=7, Ry=0x1234 -> result=7; PASSR with the same operands -> result=0x1234.
REQ-037 ADD A=0x7FFF, Ry=1 -> result=0x8000, overflow=1, carry=0; ADD A=0xFFFF, Ry=1 -> result=0, carry=1, zero=1.
REQ-038 Reset low while in_valid=1 with ADD 2+1 -> result=0, zero=1, out_valid=0; SHL A=0x8001 after release -> result=0x0002.
